// File: rtl/hazard_unit.sv
// Pipeline hazard/stall controller: load-use interlock, branch redirect flush,
// data-memory wait freeze with watchdog. Optional HAZARD_PERF_EN adds perf counters.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic       if_id_uses_rs1,
  input  logic       if_id_uses_rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mem_wb_flush,
  output logic       redirect_en,
  output logic       mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic             freeze_s;
  logic             load_use_s;
  logic             redirect_s;
  logic             lu_stall_s;

  assign cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
  assign load_use_s = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((if_id_uses_rs1 && (if_id_rs1 == id_ex_rd)) ||
                       (if_id_uses_rs2 && (if_id_rs2 == id_ex_rd)));
  assign redirect_s = !freeze_s && ex_branch_taken;
  assign lu_stall_s = !freeze_s && !ex_branch_taken && load_use_s;

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next state, wait counter and freeze decode; the RUN cycle that stalls counts as 1
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    freeze_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze_s = 1'b1;
          state_s  = ST_WAIT;
          cnt_s    = CNT_W'(1);
        end else begin
          state_s  = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          state_s = ST_RUN;
        end else begin
          freeze_s = 1'b1;
          cnt_s    = cnt_inc_s;
          if (cnt_inc_s >= CNT_LIMIT) begin
            state_s = ST_HALT;
          end else begin
            state_s = ST_WAIT;
          end
        end
      end
      ST_HALT: begin
        freeze_s = 1'b1;
      end
      default: begin
        freeze_s = 1'b1;
        state_s  = ST_HALT;
      end
    endcase
  end

  // Pipeline control decode; reset forces bubbles everywhere without waiting for a clock
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    redirect_en  = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (freeze_s) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (redirect_s) begin
      redirect_en  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (lu_stall_s) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end else begin
      pc_en        = 1'b1;
    end
  end

  assign mem_timeout = (state_r == ST_HALT);

`ifdef HAZARD_PERF_EN
  // Free-running performance counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (freeze_s || lu_stall_s) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (redirect_s) begin
        flush_events <= flush_events + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MEM_TIMEOUT = 4).
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic       if_id_uses_rs1, if_id_uses_rs2, id_ex_mem_read;
  logic       ex_branch_taken, dmem_req, dmem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic       if_id_flush, id_ex_flush, mem_wb_flush, redirect_en, mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int tests = 0;
  int failed = 0;

  // {pc_en,if_id_en,id_ex_en,ex_mem_en, if_id_flush,id_ex_flush,mem_wb_flush, redirect_en, mem_timeout}
  logic [8:0] outs;
  assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                 if_id_flush, id_ex_flush, mem_wb_flush, redirect_en, mem_timeout};

  localparam logic [8:0] NORMAL = 9'b1111_000_0_0;
  localparam logic [8:0] FREEZE = 9'b0000_001_0_0;
  localparam logic [8:0] REDIR  = 9'b1111_110_1_0;
  localparam logic [8:0] LU     = 9'b0011_010_0_0;
  localparam logic [8:0] HALTED = 9'b0000_001_0_1;
  localparam logic [8:0] RESET  = 9'b0000_111_0_0;

  hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .redirect_en(redirect_en), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle inputs 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; id_ex_rd = 5'd0;
    if_id_uses_rs1 = 1'b0; if_id_uses_rs2 = 1'b0; id_ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    tests++;
    if (outs !== RESET) begin failed++; $display("FAIL reset_async: got %b want %b", outs, RESET); end
    step(); step();
    #2;
    tests++;
    if (outs !== RESET) begin failed++; $display("FAIL reset_held: got %b want %b", outs, RESET); end
    rst_n = 1'b1;
    #1;
    tests++;
    if (outs !== NORMAL) begin failed++; $display("FAIL reset_release: got %b want %b", outs, NORMAL); end
    step();
  endtask

  task automatic test_load_use();
    // lw x5 in EX, add x6,x5,x1 in ID
    id_ex_rd = 5'd5; id_ex_mem_read = 1'b1;
    if_id_rs1 = 5'd5; if_id_rs2 = 5'd1; if_id_uses_rs1 = 1'b1; if_id_uses_rs2 = 1'b1;
    #3;
    tests++;
    if (outs !== LU) begin failed++; $display("FAIL load_use_stall: got %b want %b", outs, LU); end
    step();
    // bubble now in EX, load moved to MEM
    id_ex_rd = 5'd0; id_ex_mem_read = 1'b0;
    #3;
    tests++;
    if (outs !== NORMAL) begin failed++; $display("FAIL load_use_one_bubble: got %b want %b", outs, NORMAL); end
    step();
    // match on rs2
    id_ex_rd = 5'd7; id_ex_mem_read = 1'b1; if_id_rs1 = 5'd1; if_id_rs2 = 5'd7;
    #3;
    tests++;
    if (outs !== LU) begin failed++; $display("FAIL load_use_rs2: got %b want %b", outs, LU); end
    // rs2 matches but is not read
    if_id_uses_rs2 = 1'b0;
    #1;
    tests++;
    if (outs !== NORMAL) begin failed++; $display("FAIL load_use_unused_rs2: got %b want %b", outs, NORMAL); end
    step();
    idle_inputs();
  endtask

  task automatic test_load_x0();
    id_ex_rd = 5'd0; id_ex_mem_read = 1'b1; if_id_rs1 = 5'd0; if_id_uses_rs1 = 1'b1;
    #3;
    tests++;
    if (outs !== NORMAL) begin failed++; $display("FAIL load_x0: got %b want %b", outs, NORMAL); end
    // matching register but producer is not a load
    id_ex_rd = 5'd9; if_id_rs1 = 5'd9; id_ex_mem_read = 1'b0;
    #1;
    tests++;
    if (outs !== NORMAL) begin failed++; $display("FAIL non_load_match: got %b want %b", outs, NORMAL); end
    step();
    idle_inputs();
  endtask

  task automatic test_branch_load_use();
    id_ex_rd = 5'd5; id_ex_mem_read = 1'b1; if_id_rs1 = 5'd5; if_id_uses_rs1 = 1'b1;
    ex_branch_taken = 1'b1;
    #3;
    tests++;
    if (outs !== REDIR) begin failed++; $display("FAIL branch_over_load_use: got %b want %b", outs, REDIR); end
    step();
    idle_inputs();
    #3;
    tests++;
    if (outs !== NORMAL) begin failed++; $display("FAIL after_redirect: got %b want %b", outs, NORMAL); end
    step();
  endtask

  task automatic test_mem_wait();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      tests++;
      if (outs !== FREEZE) begin failed++; $display("FAIL mem_wait_freeze[%0d]: got %b want %b", i, outs, FREEZE); end
      step();
    end
    dmem_ready = 1'b1;
    #3;
    tests++;
    if (outs !== NORMAL) begin failed++; $display("FAIL mem_wait_release: got %b want %b", outs, NORMAL); end
    step();
    // k = 0: no freeze, and proves the FSM is back in RUN
    #3;
    tests++;
    if (outs !== NORMAL) begin failed++; $display("FAIL mem_k0: got %b want %b", outs, NORMAL); end
    step();
    dmem_ready = 1'b0;
    #3;
    tests++;
    if (outs !== FREEZE) begin failed++; $display("FAIL mem_refreeze: got %b want %b", outs, FREEZE); end
    step();
    dmem_ready = 1'b1;
    #3;
    tests++;
    if (outs !== NORMAL) begin failed++; $display("FAIL mem_k1_release: got %b want %b", outs, NORMAL); end
    step();
    idle_inputs();
  endtask

  task automatic test_freeze_branch();
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    id_ex_rd = 5'd3; id_ex_mem_read = 1'b1; if_id_rs1 = 5'd3; if_id_uses_rs1 = 1'b1;
    #3;
    tests++;
    if (outs !== FREEZE) begin failed++; $display("FAIL freeze_over_branch: got %b want %b", outs, FREEZE); end
    step();
    dmem_ready = 1'b1;
    #3;
    tests++;
    if (outs !== REDIR) begin failed++; $display("FAIL branch_after_release: got %b want %b", outs, REDIR); end
    step();
    // branch retired; held load-use in ID (no longer flushed scenario) resolves now
    dmem_req = 1'b0; dmem_ready = 1'b0; ex_branch_taken = 1'b0;
    #3;
    tests++;
    if (outs !== LU) begin failed++; $display("FAIL load_use_after_release: got %b want %b", outs, LU); end
    step();
    idle_inputs();
  endtask

  task automatic test_timeout();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #3;
      tests++;
      if (outs !== FREEZE) begin failed++; $display("FAIL timeout_wait[%0d]: got %b want %b", i, outs, FREEZE); end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      #3;
      tests++;
      if (outs !== HALTED) begin failed++; $display("FAIL timeout_halt[%0d]: got %b want %b", i, outs, HALTED); end
      dmem_ready = 1'b1; dmem_req = 1'b0;
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (outs !== RESET) begin failed++; $display("FAIL reset_in_halt: got %b want %b", outs, RESET); end
    idle_inputs();
    step();
    rst_n = 1'b1;
    #3;
    tests++;
    if (outs !== NORMAL) begin failed++; $display("FAIL after_halt_reset: got %b want %b", outs, NORMAL); end
    step();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    rst_n = 1'b1;
    step();
    id_ex_rd = 5'd5; id_ex_mem_read = 1'b1; if_id_rs1 = 5'd5; if_id_uses_rs1 = 1'b1;
    step();
    idle_inputs();
    dmem_req = 1'b1;
    step(); step(); step();
    dmem_ready = 1'b1;
    step();
    idle_inputs();
    ex_branch_taken = 1'b1;
    step();
    idle_inputs();
    step();
    tests++;
    if (stall_cycles !== 32'd4) begin failed++; $display("FAIL perf_stalls: got %0d want 4", stall_cycles); end
    tests++;
    if (flush_events !== 32'd1) begin failed++; $display("FAIL perf_flushes: got %0d want 1", flush_events); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_load_x0();
    test_branch_load_use();
    test_mem_wait();
    test_freeze_branch();
    test_timeout();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the 5-stage core. Sits upstream of the ID/EX pipeline register, and so of the forwarding unit. Resolves the hazards forwarding cannot cover:
- load-use interlock,
- taken-branch redirect flush,
- multi-cycle data-memory wait freeze.

It drives the enable and flush controls of the PC and of every pipeline register, and runs a memory-wait watchdog.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 64: consecutive memory-wait cycles before the watchdog trips (≥2).
- `CNT_W`, default 8: width of the wait counter; must hold `MEM_TIMEOUT`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_id_rs1`, `if_id_rs2` in 5: source registers of the instruction in ID.
- `if_id_uses_rs1`, `if_id_uses_rs2` in 1: the ID instruction actually reads rs1/rs2.
- `id_ex_rd` in 5: destination register of the instruction in EX.
- `id_ex_mem_read` in 1: the EX instruction is a load.
- `ex_branch_taken` in 1: EX resolved a taken branch or jump.
- `dmem_req` in 1: MEM stage holds a load or store.
- `dmem_ready` in 1: data memory completes the MEM access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` out 1: register update enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` out 1: load a bubble (NOP, reg_write=0) on the next edge.
- `redirect_en` out 1: PC takes the branch target.
- `mem_timeout` out 1: sticky watchdog error; the pipeline is halted.

## Operation
- State machine, states RUN, WAIT and HALT. Reset state is RUN.
- `freeze` is asserted:
  - in RUN when `dmem_req && !dmem_ready`;
  - in WAIT when `!dmem_ready`;
  - always in HALT.
- `load_use` = `id_ex_mem_read && id_ex_rd != 0 && ((if_id_uses_rs1 && if_id_rs1 == id_ex_rd) || (if_id_uses_rs2 && if_id_rs2 == id_ex_rd))`.
- Priority is freeze, then redirect, then load-use, then normal.
  - Freeze: all `*_en` = 0, `mem_wb_flush` = 1, `redirect_en` = 0, other flushes 0.
  - Redirect (`ex_branch_taken`): all `*_en` = 1, `redirect_en` = 1, `if_id_flush` = `id_ex_flush` = 1. A coincident load-use condition is ignored because its instruction is being flushed.
  - Load-use: `pc_en` = `if_id_en` = 0, `id_ex_flush` = 1, `ex_mem_en` = 1. Exactly one bubble is inserted.
  - Normal: all `*_en` = 1, all flushes 0, `redirect_en` = 0.
- State transitions:
  - RUN to WAIT when `dmem_req && !dmem_ready`.
  - WAIT to RUN on `dmem_ready`. That cycle is unfrozen (combinational release).
  - WAIT to HALT when the wait counter reaches `MEM_TIMEOUT`.
  - HALT is left only by reset.
- Wait counter:
  - Cleared on entry to WAIT from RUN, with the first frozen cycle counting as 1.
  - Increments each WAIT cycle and saturates; it never wraps.
- `mem_timeout` = 1 in HALT only.
- A branch held in EX during a freeze re-asserts `ex_branch_taken` after release. The redirect is never lost or duplicated.
- A load-use condition during a freeze is resolved after release.

## Timing
- Control outputs are combinational from state and inputs, with zero-cycle latency. Registers act on the same edge.
- A load-use hazard costs exactly 1 stall cycle. A redirect costs 2 flushed slots.
- For a memory access with `dmem_ready` k cycles after `dmem_req`, the freeze lasts exactly k cycles. With k = 0 there is no freeze.
- While `rst_n` = 0, asynchronously:
  - state = RUN, counter = 0, `mem_timeout` = 0;
  - all `*_en` = 0, `if_id_flush` = `id_ex_flush` = `mem_wb_flush` = 1, `redirect_en` = 0.
- Reset mid-WAIT or in HALT returns to RUN with all state cleared. The first edge after deassertion is a normal cycle.

## Configuration
- `HAZARD_PERF_EN` defined adds two 32-bit outputs, `stall_cycles` and `flush_events`, both reset to 0 and wrapping modulo 2^32.
  - `stall_cycles` increments each freeze or load-use cycle.
  - `flush_events` increments each redirect cycle.
- `HAZARD_PERF_EN` undefined: these ports and registers are absent. Control behaviour is identical either way.

## Test plan
- Load-use: `lw x5` in EX (`id_ex_rd`=5, `id_ex_mem_read`=1), `add x6,x5,x1` in ID. Required: one cycle with `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1, then normal.
- Load into x0 (`id_ex_rd`=0) matching `if_id_rs1`=0. Required: no stall.
- Taken branch coincident with load-use. Required: `redirect_en`=1, `if_id_flush`=`id_ex_flush`=1, `pc_en`=1.
- `dmem_req`=1 with `dmem_ready` high 3 cycles later. Required: 3 frozen cycles (`mem_wb_flush`=1), release in the ready cycle, state back to RUN.
- `dmem_ready` held low with `MEM_TIMEOUT`=4. Required: HALT with `mem_timeout`=1 from cycle 4 on. Asserting `rst_n`=0 mid-HALT clears it immediately.
- With `HAZARD_PERF_EN`: 1 load-use + 3 freeze cycles + 1 redirect give `stall_cycles`=4, `flush_events`=1.
